// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: LSB-first data, optional even/odd parity, 1 or 2 stop bits.
// Words are taken on a valid/ready handshake and every bit lasts OS_TICKS baud_tick strobes.
module uart_tx_cfg #(
   parameter int DATA_W   = 8,
   parameter int OS_TICKS = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              baud_tick,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic [1:0]        cfg_parity,
   input  logic              cfg_stop2,
   output logic              tx,
   output logic              tx_busy,
   output logic              tx_done
);

   localparam int TW = $clog2(OS_TICKS);
   localparam int BW = $clog2(DATA_W);
   localparam logic [TW-1:0] TICK_LAST = TW'(OS_TICKS - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t            r_state;
   logic [TW-1:0]     r_tickCnt;
   logic [BW-1:0]     r_bitCnt;
   logic              r_stopCnt;
   logic [DATA_W-1:0] r_data;
   logic [1:0]        r_parity;
   logic              r_stop2;
   logic              r_tx;
   logic              r_busy;
   logic              r_done;

   state_t            w_stateNext;
   logic [TW-1:0]     w_tickNext;
   logic [BW-1:0]     w_bitNext;
   logic [BW-1:0]     w_bitInc;
   logic              w_stopNext;
   logic              w_txNext;
   logic              w_busyNext;
   logic              w_doneNext;
   logic              w_accept;
   logic              w_advance;
   logic              w_parityEn;
   logic              w_parityBit;

   // Frame settings are frozen at accept so mid-frame cfg changes cannot corrupt the frame.
   assign w_advance   = baud_tick && (r_tickCnt == TICK_LAST);
   assign w_parityEn  = (r_parity == 2'b01) || (r_parity == 2'b10);
   assign w_parityBit = (r_parity == 2'b01) ? ^r_data : ~^r_data;
   assign w_bitInc    = r_bitCnt + 1'b1;

   assign s_ready = (r_state == IDLE);
   assign tx      = r_tx;
   assign tx_busy = r_busy;
   assign tx_done = r_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_tickCnt <= '0;
         r_bitCnt  <= '0;
         r_stopCnt <= 1'b0;
         r_data    <= '0;
         r_parity  <= 2'b00;
         r_stop2   <= 1'b0;
         r_tx      <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_stateNext;
         r_tickCnt <= w_tickNext;
         r_bitCnt  <= w_bitNext;
         r_stopCnt <= w_stopNext;
         r_tx      <= w_txNext;
         r_busy    <= w_busyNext;
         r_done    <= w_doneNext;
         if (w_accept) begin
            r_data   <= s_data;
            r_parity <= cfg_parity;
            r_stop2  <= cfg_stop2;
         end
      end
   end

   // The line value is computed one state ahead so tx comes straight from a flop.
   always_comb begin
      w_stateNext = r_state;
      w_tickNext  = r_tickCnt;
      w_bitNext   = r_bitCnt;
      w_stopNext  = r_stopCnt;
      w_txNext    = r_tx;
      w_busyNext  = r_busy;
      w_doneNext  = 1'b0;
      w_accept    = 1'b0;

      if ((r_state != IDLE) && baud_tick) begin
         w_tickNext = w_advance ? '0 : r_tickCnt + 1'b1;
      end

      case (r_state)
         IDLE: begin
            if (s_valid) begin
               w_accept    = 1'b1;
               w_stateNext = START;
               w_tickNext  = '0;
               w_bitNext   = '0;
               w_stopNext  = 1'b0;
               w_txNext    = 1'b0;
               w_busyNext  = 1'b1;
            end
         end
         START: begin
            if (w_advance) begin
               w_stateNext = DATA;
               w_bitNext   = '0;
               w_txNext    = r_data[0];
            end
         end
         DATA: begin
            if (w_advance) begin
               if (r_bitCnt == BIT_LAST) begin
                  w_stateNext = w_parityEn ? PARITY : STOP;
                  w_txNext    = w_parityEn ? w_parityBit : 1'b1;
               end else begin
                  w_bitNext = w_bitInc;
                  w_txNext  = r_data[w_bitInc];
               end
            end
         end
         PARITY: begin
            if (w_advance) begin
               w_stateNext = STOP;
               w_txNext    = 1'b1;
            end
         end
         STOP: begin
            if (w_advance) begin
               if (r_stop2 && !r_stopCnt) begin
                  w_stopNext = 1'b1;
               end else begin
                  w_stateNext = IDLE;
                  w_stopNext  = 1'b0;
                  w_busyNext  = 1'b0;
                  w_doneNext  = 1'b1;
               end
            end
         end
         default: begin
            w_stateNext = IDLE;
            w_txNext    = 1'b1;
            w_busyNext  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: table of frames with hand-computed line patterns,
// plus hand-written back-to-back, mid-frame reset and 5-bit build sequences.
module tb_uart_tx_cfg;

   typedef struct {
      logic [7:0]  data;
      logic [1:0]  par;
      logic        stop2;
      logic        flip;
      int          div;
      int          len;
      logic [11:0] bits;
      string       name;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       baud_tick;
   logic       s_valid, s_ready;
   logic [7:0] s_data;
   logic [1:0] cfg_parity;
   logic       cfg_stop2;
   logic       tx, tx_busy, tx_done;

   logic       s_valid5, s_ready5;
   logic [4:0] s_data5;
   logic [1:0] cfg_parity5;
   logic       cfg_stop25;
   logic       tx5, tx_busy5, tx_done5;

   int total = 0;
   int bad = 0;
   int tickDiv = 1;
   int tickPhase = 0;
   int tickTotal = 0;
   vec_t vecs[7];

   uart_tx_cfg #(.DATA_W(8), .OS_TICKS(16)) dut (
      .clk(clk), .rst(rst), .baud_tick(baud_tick),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
      .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
   );

   uart_tx_cfg #(.DATA_W(5), .OS_TICKS(4)) dut5 (
      .clk(clk), .rst(rst), .baud_tick(baud_tick),
      .s_valid(s_valid5), .s_ready(s_ready5), .s_data(s_data5),
      .cfg_parity(cfg_parity5), .cfg_stop2(cfg_stop25),
      .tx(tx5), .tx_busy(tx_busy5), .tx_done(tx_done5)
   );

   always #5 clk = ~clk;

   // baud_tick strobes once every tickDiv clocks, driven away from the active edge.
   initial begin
      baud_tick = 1'b0;
      forever begin
         @(negedge clk);
         tickPhase = tickPhase + 1;
         baud_tick = ((tickPhase % tickDiv) == 0);
      end
   end

   always @(posedge clk) begin
      if (baud_tick) tickTotal <= tickTotal + 1;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      s_data     = v.data;
      cfg_parity = v.par;
      cfg_stop2  = v.stop2;
      s_valid    = 1'b1;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      checkOutput({v.name, "_accept"}, {tx, tx_busy, s_ready}, 3'b010);
   endtask

   // Follows one frame by counting baud ticks since accept and samples each bit mid-period.
   task automatic monitorFrame(input vec_t v);
      int t0, rel, prevRel, c16, c32, bound;
      logic seen;
      t0 = tickTotal;
      prevRel = 0;
      c16 = -1;
      c32 = -1;
      seen = 1'b0;
      bound = v.len * 16 * v.div + 40;
      for (int c = 1; c <= bound && !seen; c++) begin
         @(posedge clk);
         #1;
         rel = tickTotal - t0;
         if (rel != prevRel) begin
            prevRel = rel;
            if (((rel % 16) == 8) && ((rel / 16) < v.len))
               checkOutput($sformatf("%s_bit%0d", v.name, rel / 16), tx, v.bits[rel / 16]);
            if (rel == 8) begin
               checkOutput({v.name, "_busy"}, {s_ready, tx_busy}, 2'b01);
               if (v.flip) begin
                  cfg_stop2  = ~cfg_stop2;
                  cfg_parity = 2'b01;
               end
            end
            if (rel == 16) c16 = c;
            if (rel == 32) c32 = c;
         end
         if (tx_done) begin
            seen = 1'b1;
            checkOutput({v.name, "_done_at"}, rel, v.len * 16);
         end
      end
      if (!seen) begin
         checkOutput({v.name, "_timeout"}, 0, 1);
      end else begin
         checkOutput({v.name, "_end_state"}, {tx, tx_busy, s_ready}, 3'b101);
         checkOutput({v.name, "_bit_clks"}, c32 - c16, 16 * v.div);
         @(posedge clk);
         #1;
         checkOutput({v.name, "_done_pulse"}, tx_done, 1'b0);
      end
   endtask

   initial begin
      int doneC;
      vec_t v;
      logic [7:0] exp5;

      s_valid = 1'b0; s_data = '0; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
      s_valid5 = 1'b0; s_data5 = '0; cfg_parity5 = 2'b00; cfg_stop25 = 1'b0;

      vecs[0] = '{8'h55, 2'b00, 1'b0, 1'b0, 1, 10, 12'h2AA, "t1_55_8n1"};
      vecs[1] = '{8'h07, 2'b01, 1'b0, 1'b0, 1, 11, 12'h60E, "t2_07_even"};
      vecs[2] = '{8'h07, 2'b10, 1'b0, 1'b0, 1, 11, 12'h40E, "t2_07_odd"};
      vecs[3] = '{8'hA3, 2'b00, 1'b1, 1'b1, 1, 11, 12'h746, "t3_a3_stop2_flip"};
      vecs[4] = '{8'h3C, 2'b10, 1'b1, 1'b0, 1, 12, 12'hE78, "3c_odd_stop2"};
      vecs[5] = '{8'hFF, 2'b11, 1'b0, 1'b0, 1, 10, 12'h3FE, "ff_par11_none"};
      vecs[6] = '{8'h80, 2'b01, 1'b1, 1'b0, 5, 12, 12'hF00, "t5_80_div5"};

      repeat (2) @(posedge clk);
      #2;
      checkOutput("reset_state", {tx, tx_busy, tx_done, s_ready}, 4'b1001);
      checkOutput("reset_state5", {tx5, tx_busy5, tx_done5, s_ready5}, 4'b1001);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         tickDiv = vecs[i].div;
         repeat (3) @(negedge clk);
         applyStimulus(vecs[i]);
         monitorFrame(vecs[i]);
      end

      // Back-to-back: s_valid stays high, second start bit right after the done pulse.
      tickDiv = 1;
      repeat (3) @(negedge clk);
      s_data = 8'h11; cfg_parity = 2'b00; cfg_stop2 = 1'b0; s_valid = 1'b1;
      @(posedge clk);
      #1;
      s_data = 8'h22;
      checkOutput("t4_first_accept", {tx, tx_busy, s_ready}, 3'b010);
      doneC = -1;
      for (int c = 1; c <= 400; c++) begin
         @(posedge clk);
         #1;
         if (c == 80) checkOutput("t4_ready_low", s_ready, 1'b0);
         if (tx_done) begin
            doneC = c;
            break;
         end
      end
      checkOutput("t4_first_done", doneC, 160);
      checkOutput("t4_ready_at_done", s_ready, 1'b1);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      checkOutput("t4_second_start", {tx, tx_busy, s_ready}, 3'b010);
      doneC = -1;
      for (int c = 1; c <= 400; c++) begin
         @(posedge clk);
         #1;
         if (c == 24) checkOutput("t4_22_d0", tx, 1'b0);
         if (c == 40) checkOutput("t4_22_d1", tx, 1'b1);
         if (tx_done) begin
            doneC = c;
            break;
         end
      end
      checkOutput("t4_second_done", doneC, 160);

      // Asynchronous reset in the middle of data bit 0 of 0x5A.
      repeat (3) @(negedge clk);
      v = '{8'h5A, 2'b00, 1'b0, 1'b0, 1, 10, 12'h2B4, "t6_5a"};
      applyStimulus(v);
      repeat (20) @(posedge clk);
      @(negedge clk);
      checkOutput("t6_pre_reset_tx", tx, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("t6_async_reset", {tx, tx_busy, tx_done, s_ready}, 4'b1001);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      applyStimulus(vecs[0]);
      monitorFrame(vecs[0]);

      // 5-bit build, OS_TICKS=4: 0x1F with odd parity gives parity bit 0.
      tickDiv = 1;
      exp5 = 8'hBE;
      @(negedge clk);
      s_data5 = 5'h1F; cfg_parity5 = 2'b10; cfg_stop25 = 1'b0; s_valid5 = 1'b1;
      @(posedge clk);
      #1;
      s_valid5 = 1'b0;
      doneC = -1;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk);
         #1;
         if (((c % 4) == 2) && ((c / 4) < 8))
            checkOutput($sformatf("w5_bit%0d", c / 4), tx5, exp5[c / 4]);
         if (tx_done5) begin
            doneC = c;
            break;
         end
      end
      checkOutput("w5_done_at", doneC, 32);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
